instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage that owns the program counter. It issues one request at a time to instruction memory and holds the returned 32-bit word for the decode/control stage under a valid/ready handshake. It also redirects the PC on a taken branch. It sits directly upstream of the control unit and drives its `instruction` input.

## Interface
- `RESET_PC`, default 64'h0: PC value loaded on reset.
- `XLEN`, default 64: PC and address width.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_req` out 1: fetch request strobe, high for exactly one cycle per request.
- `imem_addr` out XLEN: fetch address; always equals the current PC.
- `imem_rvalid` in 1: response strobe; must arrive at least 1 cycle after `imem_req`.
- `imem_rdata` in 32: instruction word, qualified by `imem_rvalid`.
- `branch_taken` in 1: single-cycle redirect pulse from the branch/ALU stage.
- `branch_target` in XLEN: redirect PC; bits [1:0] are forced to 0 internally.
- `if_valid` out 1: `instruction`/`if_pc` hold a valid fetched word.
- `if_ready` in 1: downstream accepts the word when `if_valid & if_ready`.
- `instruction` out 32: registered instruction word to decode.
- `if_pc` out XLEN: PC of `instruction`.

## Operation
- FSM states:
  - IDLE: reset state. Unconditionally moves to FETCH on the next edge.
  - FETCH: `imem_req = !branch_taken`. Moves to WAIT if the request was issued; stays in FETCH if it was suppressed.
  - WAIT: one request is outstanding.
    - On `imem_rvalid`: latch `imem_rdata` into `instruction` and the PC into `if_pc`, set `if_valid`, set `pc <= pc + 4`, go to HOLD.
  - HOLD: `if_valid = 1`. On `if_valid & if_ready`: clear `if_valid`, go to FETCH.
  - DROP: a stale response is outstanding. On `imem_rvalid`: discard the data, go to FETCH.
- Redirect: `branch_taken` in any state except IDLE sets `pc <= {branch_target[XLEN-1:2], 2'b00}`. Per-state action:
  - FETCH: request suppressed this cycle; stay in FETCH.
  - WAIT without `imem_rvalid`: go to DROP.
  - WAIT with `imem_rvalid` in the same cycle: discard the data, go to FETCH, `if_valid` stays 0.
  - HOLD: clear `if_valid` even if `if_ready` is high, go to FETCH.
  - DROP: stay in DROP. If `imem_rvalid` arrives in the same cycle, go to FETCH.
  - IDLE: `branch_taken` is ignored.
- PC arithmetic is unsigned XLEN-bit, wrapping modulo 2^XLEN: 64'hFFFF_FFFF_FFFF_FFFC + 4 = 0.
- `imem_rvalid` in IDLE, FETCH or HOLD is a protocol violation. It is ignored, and no state or output changes.
- At most one request is outstanding at any time. A new request is never issued before the previous response has been received, whether consumed or dropped.
- `instruction` and `if_pc` change only on the WAIT->HOLD capture. They remain stable while `if_valid` is high.

## Timing
- Reset values (asynchronous, on `rst_n` low):
  - state = IDLE
  - pc = `RESET_PC`
  - `imem_req` = 0
  - `imem_addr` = `RESET_PC`
  - `if_valid` = 0
  - `instruction` = 32'h0
  - `if_pc` = `RESET_PC`
- Reset asserted mid-operation (any state) returns everything to the values above immediately. A response arriving after reset release is ignored, because the FSM is in IDLE or FETCH.
- Cycle numbering: edge 0 is the first rising edge after `rst_n` deasserts. Edge 0 moves IDLE->FETCH, and `imem_req` is high in cycle 1.
- Minimum response path: `imem_rvalid` in the cycle after the request gives `if_valid` high one edge later.
- With 1-cycle memory and `if_ready` held high, the block fetches one instruction per 3 cycles: FETCH, WAIT, HOLD.
- `imem_req` and `imem_addr` are combinational from state and PC. All other outputs are registered.
- `if_valid` may not be withdrawn without a handshake, except by redirect or reset.

## Test plan
- Sequential fetch: reset with `RESET_PC` = 0; memory returns `imem_rdata` = 32'h00A00093 one cycle after each request; `if_ready` = 1.
  - Required: `imem_addr` runs 0, 4, 8 in successive FETCH cycles.
  - Required: `if_pc` and `instruction` are handed off every 3 cycles.
- Backpressure: hold `if_ready` = 0 for 5 cycles after `if_valid` rises.
  - Required: `if_valid`, `instruction` and `if_pc` stay stable, and `imem_req` stays 0.
  - Required: after `if_ready` = 1, exactly one handshake occurs, then the next request goes to pc + 4.
- Redirect in WAIT: request issued at 0x10, then `branch_taken` with `branch_target` = 0x103 before the response arrives.
  - Required: the late response is discarded and `if_valid` never rises for it.
  - Required: the next `imem_addr` = 0x100.
- Redirect coincident with response: `branch_taken` (target 0x40) in the same cycle as `imem_rvalid`.
  - Required: the data is discarded, the FSM goes directly to FETCH, and the next `imem_addr` = 0x40.
- Redirect in HOLD with `if_ready` = 1 in the same cycle: no handshake counted, `if_valid` drops to 0, and the next fetch is at the target address.
- Wrap and reset: `RESET_PC` = 64'hFFFF_FFFF_FFFF_FFFC.
  - Required: the second fetch address is 0.
  - Assert `rst_n` low while in WAIT. Required: all outputs return to their reset values asynchronously, and a stray `imem_rvalid` after release is ignored.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues one imem request at a time and
// holds the returned word for decode under a valid/ready handshake. A taken
// branch redirects the PC and squashes any in-flight or held fetch.
module instr_fetch #(
   parameter int unsigned     XLEN     = 64,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_rvalid,
   input  logic [31:0]     imem_rdata,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] branch_target,
   output logic            if_valid,
   input  logic            if_ready,
   output logic [31:0]     instruction,
   output logic [XLEN-1:0] if_pc
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_FETCH = 3'd1;
   localparam logic [2:0] ST_WAIT  = 3'd2;
   localparam logic [2:0] ST_HOLD  = 3'd3;
   localparam logic [2:0] ST_DROP  = 3'd4;

   localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

   logic [2:0]      state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            valid_q, valid_d;
   logic [31:0]     instr_q, instr_d;
   logic [XLEN-1:0] if_pc_q, if_pc_d;
   logic [XLEN-1:0] redirect_pc;

   // Target is word aligned; the low two bits are dropped on purpose.
   logic unused_target_lsb;
   assign unused_target_lsb = ^branch_target[1:0];
   assign redirect_pc       = {branch_target[XLEN-1:2], 2'b00};

   // Request strobe and address come straight from state and PC.
   always_comb begin
      imem_req  = (state_q == ST_FETCH) && !branch_taken;
      imem_addr = pc_q;
   end

   assign if_valid    = valid_q;
   assign instruction = instr_q;
   assign if_pc       = if_pc_q;

   // Next-state logic; stray rvalid outside WAIT/DROP is ignored.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      valid_d = valid_q;
      instr_d = instr_q;
      if_pc_d = if_pc_q;
      case (state_q)
         ST_IDLE: state_d = ST_FETCH;
         ST_FETCH: begin
            if (!branch_taken) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (imem_rvalid) begin
               if (branch_taken) begin
                  // Response arrived but is already stale; drop it.
                  state_d = ST_FETCH;
               end else begin
                  instr_d = imem_rdata;
                  if_pc_d = pc_q;
                  valid_d = 1'b1;
                  pc_d    = pc_q + PC_STEP;
                  state_d = ST_HOLD;
               end
            end else if (branch_taken) begin
               state_d = ST_DROP;
            end
         end
         ST_HOLD: begin
            if (branch_taken || if_ready) begin
               valid_d = 1'b0;
               state_d = ST_FETCH;
            end
         end
         ST_DROP: begin
            if (imem_rvalid) state_d = ST_FETCH;
         end
         default: state_d = ST_IDLE;
      endcase
      if (branch_taken && (state_q != ST_IDLE)) pc_d = redirect_pc;
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         pc_q    <= RESET_PC;
         valid_q <= 1'b0;
         instr_q <= 32'h0;
         if_pc_q <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
         instr_q <= instr_d;
         if_pc_q <= if_pc_d;
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: two instances (RESET_PC 0 and 2^64-4) share stimulus
// and are checked every cycle against a transaction-level model.
module tb_instr_fetch;

   localparam logic [63:0] RPC0 = 64'h0;
   localparam logic [63:0] RPC1 = 64'hFFFF_FFFF_FFFF_FFFC;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        branch_taken = 1'b0;
   logic [63:0] branch_target = 64'h0;
   logic        if_ready = 1'b0;

   logic        req_a [2];
   logic [63:0] addr_a[2];
   logic        vld_a [2];
   logic [31:0] ins_a [2];
   logic [63:0] ifpc_a[2];

   instr_fetch #(.XLEN(64), .RESET_PC(RPC0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .imem_req(req_a[0]), .imem_addr(addr_a[0]),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .branch_taken(branch_taken),
      .branch_target(branch_target), .if_valid(vld_a[0]), .if_ready(if_ready),
      .instruction(ins_a[0]), .if_pc(ifpc_a[0])
   );

   instr_fetch #(.XLEN(64), .RESET_PC(RPC1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .imem_req(req_a[1]), .imem_addr(addr_a[1]),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .branch_taken(branch_taken),
      .branch_target(branch_target), .if_valid(vld_a[1]), .if_ready(if_ready),
      .instruction(ins_a[1]), .if_pc(ifpc_a[1])
   );

   // Transaction view: started after reset, a request in flight (maybe stale),
   // a held word, and the next PC to fetch.
   typedef struct packed {
      logic        started;
      logic        out;
      logic        stale;
      logic        hold;
      logic [63:0] pc;
      logic [63:0] ifpc;
      logic [31:0] instr;
   } mdl_t;

   mdl_t        m[2];
   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc_n = 0;
   logic        last_req = 1'b0;
   logic [63:0] addr_log0[$];
   logic [63:0] addr_log1[$];
   int          hs_log[$];

   function automatic mdl_t mdl_reset(input logic [63:0] rpc);
      mdl_t s;
      s.started = 1'b0; s.out = 1'b0; s.stale = 1'b0; s.hold = 1'b0;
      s.pc = rpc; s.ifpc = rpc; s.instr = 32'h0;
      return s;
   endfunction

   function automatic logic exp_req(input mdl_t s);
      return s.started && !s.out && !s.hold && !branch_taken;
   endfunction

   function automatic mdl_t mdl_step(input mdl_t s, input logic rv, input logic bt,
                                     input logic [63:0] tgt, input logic rdy,
                                     input logic [31:0] rd);
      mdl_t n = s;
      if (!s.started) begin
         n.started = 1'b1;
         return n;
      end
      if (!s.out && !s.hold) begin
         if (!bt) begin n.out = 1'b1; n.stale = 1'b0; end
      end else if (s.out && rv) begin
         n.out = 1'b0;
         if (!s.stale && !bt) begin
            n.hold = 1'b1; n.instr = rd; n.ifpc = s.pc; n.pc = s.pc + 64'd4;
         end
      end
      if (s.hold && (bt || rdy)) n.hold = 1'b0;
      if (bt) begin
         n.pc = {tgt[63:2], 2'b00};
         if (n.out) n.stale = 1'b1;
      end
      return n;
   endfunction

   function automatic logic [63:0] qget(input logic [63:0] q[$], input int i);
      if (i < q.size()) return q[i];
      return 64'hx;
   endfunction

   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < 2; i++) begin
         cmp($sformatf("imem_req%0d", i), 64'(req_a[i]), 64'(exp_req(m[i])));
         cmp($sformatf("imem_addr%0d", i), addr_a[i], m[i].pc);
         cmp($sformatf("if_valid%0d", i), 64'(vld_a[i]), 64'(m[i].hold));
         cmp($sformatf("instruction%0d", i), 64'(ins_a[i]), 64'(m[i].instr));
         cmp($sformatf("if_pc%0d", i), ifpc_a[i], m[i].ifpc);
      end
   endtask

   // One clock: drive at negedge, check, then advance the model at posedge.
   task automatic cyc(input logic rv, input logic bt, input logic [63:0] tgt,
                      input logic rdy, input logic use_auto, input logic [31:0] rd);
      @(negedge clk);
      imem_rvalid   = use_auto ? last_req : rv;
      branch_taken  = bt;
      branch_target = tgt;
      if_ready      = rdy;
      imem_rdata    = rd;
      #1;
      check_all();
      if (req_a[0]) addr_log0.push_back(addr_a[0]);
      if (req_a[1]) addr_log1.push_back(addr_a[1]);
      if (vld_a[0] && rdy && !bt) hs_log.push_back(cyc_n);
      last_req = req_a[0];
      @(posedge clk);
      if (rst_n) begin
         for (int i = 0; i < 2; i++)
            m[i] = mdl_step(m[i], imem_rvalid, bt, tgt, rdy, rd);
      end
      cyc_n++;
      #1;
   endtask

   // Assert reset between edges and check outputs before any clock edge.
   task automatic do_reset();
      @(negedge clk);
      imem_rvalid = 1'b0; branch_taken = 1'b0; if_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      m[0] = mdl_reset(RPC0);
      m[1] = mdl_reset(RPC1);
      check_all();
      cmp("rst_req", 64'(req_a[0]), 64'h0);
      cmp("rst_valid", 64'(vld_a[0]), 64'h0);
      cmp("rst_instr", 64'(ins_a[1]), 64'h0);
      cmp("rst_addr1", addr_a[1], RPC1);
      cmp("rst_ifpc1", ifpc_a[1], RPC1);
      @(posedge clk);
      #1 rst_n = 1'b1;
      cyc_n = 0;
      last_req = 1'b0;
      addr_log0.delete();
      addr_log1.delete();
      hs_log.delete();
   endtask

   logic [31:0] saved_ins;
   logic [63:0] saved_pc;
   int          n_hs;

   initial begin
      m[0] = mdl_reset(RPC0);
      m[1] = mdl_reset(RPC1);
      do_reset();

      // Sequential fetch, 1-cycle memory, ready held high.
      for (int k = 0; k < 10; k++) cyc(1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 32'h00A00093);
      cmp("seq_addr0", qget(addr_log0, 0), 64'h0);
      cmp("seq_addr1", qget(addr_log0, 1), 64'h4);
      cmp("seq_addr2", qget(addr_log0, 2), 64'h8);
      cmp("wrap_addr0", qget(addr_log1, 0), RPC1);
      cmp("wrap_addr1", qget(addr_log1, 1), 64'h0);
      cmp("hs_cyc0", 64'(hs_log.size() > 0 ? hs_log[0] : -1), 64'd3);
      cmp("hs_cyc1", 64'(hs_log.size() > 1 ? hs_log[1] : -1), 64'd6);
      cmp("hs_cyc2", 64'(hs_log.size() > 2 ? hs_log[2] : -1), 64'd9);
      cmp("seq_instr", 64'(ins_a[0]), 64'h00A00093);

      // Backpressure: five cycles of if_ready low while holding.
      cyc(1'b0, 1'b0, 64'h0, 1'b0, 1'b1, $urandom);
      cyc(1'b0, 1'b0, 64'h0, 1'b0, 1'b1, $urandom);
      saved_ins = ins_a[0];
      saved_pc  = ifpc_a[0];
      cmp("bp_ifpc", saved_pc, 64'hC);
      n_hs = hs_log.size();
      for (int k = 0; k < 5; k++) begin
         cyc(1'b0, 1'b0, 64'h0, 1'b0, 1'b1, $urandom);
         cmp("bp_valid", 64'(vld_a[0]), 64'h1);
         cmp("bp_instr", 64'(ins_a[0]), 64'(saved_ins));
         cmp("bp_pc", ifpc_a[0], saved_pc);
         cmp("bp_req", 64'(req_a[0]), 64'h0);
      end
      cyc(1'b0, 1'b0, 64'h0, 1'b1, 1'b1, $urandom);
      cmp("bp_one_hs", 64'(hs_log.size() - n_hs), 64'h1);
      cyc(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, $urandom);
      cmp("bp_next_addr", addr_log0[$], 64'h10);

      // Redirect while a request is outstanding; late response is dropped.
      cyc(1'b0, 1'b1, 64'h103, 1'b1, 1'b0, $urandom);
      cyc(1'b1, 1'b0, 64'h0, 1'b1, 1'b0, $urandom);
      cmp("drop_valid", 64'(vld_a[0]), 64'h0);
      cyc(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, $urandom);
      cmp("redir_addr0", addr_log0[$], 64'h100);
      cmp("redir_addr1", addr_log1[$], 64'h100);
      cyc(1'b1, 1'b0, 64'h0, 1'b1, 1'b0, $urandom);
      cyc(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, $urandom);

      // Redirect coincident with the response.
      cyc(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, $urandom);
      cyc(1'b1, 1'b1, 64'h40, 1'b1, 1'b0, $urandom);
      cmp("coin_valid", 64'(vld_a[0]), 64'h0);
      cyc(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, $urandom);
      cmp("coin_addr", addr_log0[$], 64'h40);

      // Redirect in HOLD with if_ready high: no handshake.
      cyc(1'b1, 1'b0, 64'h0, 1'b0, 1'b0, $urandom);
      cmp("hold_valid", 64'(vld_a[0]), 64'h1);
      n_hs = hs_log.size();
      cyc(1'b0, 1'b1, 64'h80, 1'b1, 1'b0, $urandom);
      cmp("hold_redir_valid", 64'(vld_a[0]), 64'h0);
      cmp("hold_redir_hs", 64'(hs_log.size() - n_hs), 64'h0);
      cyc(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, $urandom);
      cmp("hold_redir_addr", addr_log0[$], 64'h80);

      // Reset while waiting, then a stray response after release.
      do_reset();
      cyc(1'b1, 1'b0, 64'h0, 1'b1, 1'b0, $urandom);
      cyc(1'b1, 1'b0, 64'h0, 1'b1, 1'b0, $urandom);
      for (int k = 0; k < 6; k++) cyc(1'b0, 1'b0, 64'h0, 1'b1, 1'b1, $urandom);
      cmp("rst_wrap0", qget(addr_log1, 0), RPC1);
      cmp("rst_wrap1", qget(addr_log1, 1), 64'h0);

      // Randomized traffic, including protocol-violating strobes and resets.
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 499) == 0) do_reset();
         cyc(($urandom_range(0, 9) < 3), ($urandom_range(0, 11) == 0),
             {$urandom, $urandom}, $urandom_range(0, 1) == 1,
             $urandom_range(0, 1) == 1, $urandom);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
